// File: rtl/lightpen_pkg.sv
// lightpen_pkg
// Shared definitions for the light-pen latch: bus register indices,
// status/control bit positions and the control-register clear bit.
// No ports; imported by lightpen_latch.
package lightpen_pkg;

    typedef enum logic [1:0] {
        LP_REG_X    = 2'd0,
        LP_REG_Y    = 2'd1,
        LP_REG_STAT = 2'd2,
        LP_REG_CTRL = 2'd3
    } lp_reg_e;

    localparam int LP_STAT_VALID   = 7;
    localparam int LP_STAT_OVERRUN = 6;
    localparam int LP_CTRL_ARMED   = 0;
    localparam int LP_CTRL_IRQ_EN  = 1;
    localparam int LP_CTRL_CLEAR   = 7;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Two-flop synchronizer for an asynchronous level, followed by a
// single-tick rising-edge pulse on the synchronized signal.
// Ports:
//   master_clock  in   system clock
//   reset         in   synchronous, active-high reset (clears all flops)
//   i_async       in   asynchronous input level
//   o_rise        out  one-tick pulse after a synchronized 0->1 transition
module sync_edge_det (
    input  logic master_clock,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Clearing every flop on reset throws away any edge still travelling
    // through the synchronizer.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/lightpen_latch.sv
// lightpen_latch
// Tracks the beam position (X in master-clock ticks, Y in scan lines)
// from the video syncs and latches it on a pen strobe. The CPU reads the
// latched position and status, and writes arm/irq-enable/clear through
// four bus registers during phi2.
// Optional interrupt output is enabled by defining LIGHTPEN_IRQ_EN.
// Ports:
//   master_clock, reset       clock, synchronous active-high reset
//   hsync, vsync              active-low syncs from the video generator
//   pen                       asynchronous pen strobe, active high
//   phi2, last                CPU phase and its final tick (write qualifier)
//   cs, rw, reg_addr, data_in register select, direction, index, write data
//   data_out, data_oe         read data and its drive enable
//   irq_n                     interrupt request, active low
module lightpen_latch
    import lightpen_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 10
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       pen,
    input  logic       phi2,
    input  logic       last,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] reg_addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       irq_n
);

    logic [X_W-1:0] r_xCnt;
    logic [Y_W-1:0] r_yCnt;
    // The two LSBs of the X latch are never readable, so they are not stored.
    logic [X_W-3:0] r_lx;
    logic [Y_W-1:0] r_ly;
    logic           r_valid;
    logic           r_overrun;
    logic           r_armed;
    logic           r_hsync;
    logic           r_vsync;
    logic           w_hFall;
    logic           w_vFall;
    logic           w_penRise;
    logic           w_write;
    logic           w_ctrlWrite;
    logic           w_clear;
    logic           w_irqEn;
    logic [7:0]     w_regData;
    logic           w_unusedBits;

    sync_edge_det u_penSync (
        .master_clock (master_clock),
        .reset        (reset),
        .i_async      (pen),
        .o_rise       (w_penRise)
    );

    // Syncs idle high, so their registered copies reset high to avoid
    // seeing a false falling edge straight out of reset.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hsync <= hsync;
            r_vsync <= vsync;
        end
    end

    assign w_hFall = r_hsync & ~hsync;
    assign w_vFall = r_vsync & ~vsync;

    // Beam position counters. Both saturate rather than wrap so a missing
    // sync never aliases back onto a plausible position.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_xCnt <= '0;
            r_yCnt <= '0;
        end else begin
            if (w_hFall) begin
                r_xCnt <= '0;
            end else if (r_xCnt != '1) begin
                r_xCnt <= r_xCnt + 1'b1;
            end
            if (w_vFall) begin
                r_yCnt <= '0;
            end else if (w_hFall && (r_yCnt != '1)) begin
                r_yCnt <= r_yCnt + 1'b1;
            end
        end
    end

    assign w_write     = cs & ~rw & phi2 & last;
    assign w_ctrlWrite = w_write & (reg_addr == LP_REG_CTRL);
    assign w_clear     = w_ctrlWrite & data_in[LP_CTRL_CLEAR];

    // Capture logic. A clear and a capture in the same tick let the capture
    // win: the clear wipes overrun and the fresh position is stored as
    // valid. Arming uses the old armed value, so a write that arms on the
    // pen-rise tick does not capture.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_lx      <= '0;
            r_ly      <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            if (w_ctrlWrite) begin
                r_armed <= data_in[LP_CTRL_ARMED];
            end
            if (w_clear) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_penRise && r_armed) begin
                if (!r_valid || w_clear) begin
                    r_lx    <= r_xCnt[X_W-1:2];
                    r_ly    <= r_yCnt;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef LIGHTPEN_IRQ_EN
    logic r_irqEn;
    logic r_irqN;

    // Interrupt enable and the registered request, one tick behind valid.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_irqEn <= 1'b0;
            r_irqN  <= 1'b1;
        end else begin
            if (w_ctrlWrite) begin
                r_irqEn <= data_in[LP_CTRL_IRQ_EN];
            end
            r_irqN <= ~(r_valid & r_irqEn);
        end
    end

    assign w_irqEn      = r_irqEn;
    assign irq_n        = r_irqN;
    assign w_unusedBits = ^data_in[6:2];
`else
    assign w_irqEn      = 1'b0;
    assign irq_n        = 1'b1;
    assign w_unusedBits = ^data_in[6:1];
`endif

    // Combinational register read mux.
    always_comb begin
        w_regData = 8'h00;
        case (reg_addr)
            LP_REG_X:    w_regData = r_lx[X_W-3 -: 8];
            LP_REG_Y:    w_regData = r_ly[7:0];
            LP_REG_STAT: begin
                w_regData[LP_STAT_VALID]   = r_valid;
                w_regData[LP_STAT_OVERRUN] = r_overrun;
                w_regData[1:0]             = r_ly[9:8];
            end
            LP_REG_CTRL: begin
                w_regData[LP_CTRL_ARMED]  = r_armed;
                w_regData[LP_CTRL_IRQ_EN] = w_irqEn;
            end
            default:     w_regData = 8'h00;
        endcase
    end

    assign data_oe  = cs & rw & phi2;
    assign data_out = data_oe ? w_regData : 8'h00;

endmodule

// File: tb/tb_lightpen_latch.sv
// tb_lightpen_latch
// Self-checking bench for lightpen_latch: a table of register accesses
// after reset, then hand-written sequences for capture, overrun, clear,
// clear-with-capture, interrupt, disarm and X saturation. Read
// expectations go through a scoreboard queue.
// Honours LIGHTPEN_IRQ_EN the same way the design does.
module tb_lightpen_latch;

    logic       master_clock = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       pen;
    logic       phi2;
    logic       last;
    logic       cs;
    logic       rw;
    logic [1:0] reg_addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       irq_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    sb_t  sbQ[$];
    vec_t vecs[10];

`ifdef LIGHTPEN_IRQ_EN
    localparam logic [7:0] CTRL_IRQ_ONLY  = 8'h02;
    localparam logic [7:0] CTRL_IRQ_ARMED = 8'h03;
    localparam logic       IRQ_ASSERTED   = 1'b0;
`else
    localparam logic [7:0] CTRL_IRQ_ONLY  = 8'h00;
    localparam logic [7:0] CTRL_IRQ_ARMED = 8'h01;
    localparam logic       IRQ_ASSERTED   = 1'b1;
`endif

    lightpen_latch #(.X_W(10), .Y_W(10)) dut (
        .master_clock (master_clock),
        .reset        (reset),
        .hsync        (hsync),
        .vsync        (vsync),
        .pen          (pen),
        .phi2         (phi2),
        .last         (last),
        .cs           (cs),
        .rw           (rw),
        .reg_addr     (reg_addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .irq_n        (irq_n)
    );

    always #5 master_clock = ~master_clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge master_clock);
    endtask

    task automatic busIdle();
        phi2 = 1'b0;
        cs   = 1'b0;
        rw   = 1'b1;
        last = 1'b0;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
        #1;
        phi2     = 1'b1;
        cs       = 1'b1;
        rw       = 1'b0;
        last     = 1'b1;
        reg_addr = addr;
        data_in  = data;
        @(posedge master_clock);
        #1 busIdle();
    endtask

    task automatic checkOutput();
        sb_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
        end else begin
            e = sbQ.pop_front();
            check(e.name, data_out, e.exp);
            check({e.name, "_oe"}, {7'b0, data_oe}, 8'h01);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] exp, input string name);
        sbQ.push_back('{name, exp});
        #1;
        phi2     = 1'b1;
        cs       = 1'b1;
        rw       = 1'b1;
        last     = 1'b0;
        reg_addr = addr;
        @(negedge master_clock);
        checkOutput();
        @(posedge master_clock);
        #1 busIdle();
    endtask

    task automatic hsyncFall();
        step(1);
        #1 hsync = 1'b0;
        step(4);
        #1 hsync = 1'b1;
    endtask

    task automatic penPulse();
        #1 pen = 1'b1;
        step(3);
        #1 pen = 1'b0;
        step(2);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 8'h00, 8'h00,          "rst_reg0"};
        vecs[1] = '{1'b0, 2'd1, 8'h00, 8'h00,          "rst_reg1"};
        vecs[2] = '{1'b0, 2'd2, 8'h00, 8'h00,          "rst_reg2"};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h00,          "rst_reg3"};
        vecs[4] = '{1'b1, 2'd3, 8'h02, 8'h00,          "wr_irqen"};
        vecs[5] = '{1'b0, 2'd3, 8'h00, CTRL_IRQ_ONLY,  "rd_irqen"};
        vecs[6] = '{1'b1, 2'd0, 8'hAA, 8'h00,          "wr_reg0"};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 8'h00,          "reg0_ignores_wr"};
        vecs[8] = '{1'b1, 2'd3, 8'h01, 8'h00,          "wr_arm"};
        vecs[9] = '{1'b0, 2'd3, 8'h00, 8'h01,          "rd_arm"};

        reset    = 1'b1;
        hsync    = 1'b1;
        vsync    = 1'b1;
        pen      = 1'b0;
        reg_addr = 2'd0;
        data_in  = 8'h00;
        busIdle();
        step(3);
        #1 reset = 1'b0;

        // Outputs outside phi2, including a selected read with phi2 low.
        cs = 1'b1;
        @(negedge master_clock);
        check("oe_no_phi2", {7'b0, data_oe}, 8'h00);
        check("dout_no_phi2", data_out, 8'h00);
        check("irq_rst", {7'b0, irq_n}, 8'h01);
        busIdle();
        @(posedge master_clock);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) busWrite(vecs[i].addr, vecs[i].data);
            else            applyStimulus(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Frame start then 100 lines; pen 400 ticks after the last line start.
        step(1);
        #1 vsync = 1'b0;
        step(4);
        #1 vsync = 1'b1;
        for (int i = 0; i < 100; i++) hsyncFall();
        step(396);
        penPulse();
        applyStimulus(2'd0, 8'h64, "cap_x");
        applyStimulus(2'd1, 8'h64, "cap_y");
        applyStimulus(2'd2, 8'h80, "cap_stat");
        check("irq_disabled", {7'b0, irq_n}, 8'h01);

        // Second strobe while valid: overrun, position kept.
        step(1);
        penPulse();
        applyStimulus(2'd0, 8'h64, "ovr_x");
        applyStimulus(2'd1, 8'h64, "ovr_y");
        applyStimulus(2'd2, 8'hC0, "ovr_stat");

        // Clear keeps armed.
        busWrite(2'd3, 8'h81);
        applyStimulus(2'd2, 8'h00, "clr_stat");
        applyStimulus(2'd3, 8'h01, "clr_armed");

        // New capture at line 101, offset 200, then overrun again.
        hsyncFall();
        step(196);
        penPulse();
        applyStimulus(2'd0, 8'h32, "cap2_x");
        applyStimulus(2'd1, 8'h65, "cap2_y");
        applyStimulus(2'd2, 8'h80, "cap2_stat");
        step(1);
        penPulse();
        applyStimulus(2'd2, 8'hC0, "ovr2_stat");

        // Clear write lands on the same tick as the capture: capture wins.
        hsyncFall();
        step(796);
        #1 pen = 1'b1;
        step(2);
        busWrite(2'd3, 8'h81);
        pen = 1'b0;
        step(2);
        applyStimulus(2'd2, 8'h80, "clrcap_stat");
        applyStimulus(2'd0, 8'hC8, "clrcap_x");
        applyStimulus(2'd1, 8'h66, "clrcap_y");

        // Interrupt: enable + clear, capture, then clear again.
        busWrite(2'd3, 8'h83);
        @(negedge master_clock);
        check("irq_after_clear", {7'b0, irq_n}, 8'h01);
        @(posedge master_clock);
        #1 pen = 1'b1;
        step(3);
        @(negedge master_clock);
        check("irq_valid_tick", {7'b0, irq_n}, 8'h01);
        @(negedge master_clock);
        check("irq_asserted", {7'b0, irq_n}, {7'b0, IRQ_ASSERTED});
        pen = 1'b0;
        @(posedge master_clock);
        busWrite(2'd3, 8'h83);
        @(negedge master_clock);
        check("irq_clear_tick", {7'b0, irq_n}, {7'b0, IRQ_ASSERTED});
        @(negedge master_clock);
        check("irq_released", {7'b0, irq_n}, 8'h01);
        @(posedge master_clock);
        applyStimulus(2'd3, CTRL_IRQ_ARMED, "rd_ctrl_irq");

        // Disarmed strobes are ignored.
        busWrite(2'd3, 8'h80);
        step(1);
        penPulse();
        applyStimulus(2'd2, 8'h00, "disarm_stat");

        // X saturates when hsync is withheld.
        busWrite(2'd3, 8'h01);
        hsyncFall();
        step(1100);
        penPulse();
        applyStimulus(2'd0, 8'hFF, "sat_x");
        applyStimulus(2'd2, 8'h80, "sat_stat");

        check("sb_empty", 8'(sbQ.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
